if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction-fetch front end placed ahead of the IF/ID pipeline register.
//  Issues in-order fetch requests to instruction memory and buffers returned
//  instructions, each with its PC, in a FIFO. Presents them first-word-fall-through
//  to IF/ID under a valid/ready handshake. A branch redirect from EX/MEM flushes
//  the queue and discards stale in-flight responses.
// PARAMETERS
//  DEPTH     4      FIFO entries; also the cap on queued + live in-flight fetches (power of 2, >=2)
//  PC_W      64     PC / address width
//  INSTR_W   32     instruction width
//  RESET_PC  64'h0  first fetch address after reset
// PORTS
//  clk             in   1        rising-edge clock
//  reset           in   1        synchronous, active-high
//  imem_req_valid  out  1        fetch request valid
//  imem_req_addr   out  PC_W     fetch address (fetch_pc)
//  imem_req_ready  in   1        memory accepts request this cycle
//  imem_resp_valid in   1        response valid; responses return in request order
//  imem_resp_data  in   INSTR_W  fetched instruction
//  redirect_valid  in   1        taken branch: flush and refetch
//  redirect_pc     in   PC_W     new fetch address
//  deq_valid       out  1        head entry valid (occupancy != 0)
//  deq_ready       in   1        IF/ID accepts (low = stall)
//  deq_pc          out  PC_W     PC of head entry
//  deq_instr       out  INSTR_W  instruction of head entry
//  occupancy       out  clog2(DEPTH+1)  entries held
// BEHAVIOUR
//  - Reset values: fetch_pc=resp_pc=RESET_PC; occupancy=0; outstanding=0; drop_cnt=0;
//    deq_valid=0; imem_req_valid=0 while reset is high. deq_pc/deq_instr are don't-care when deq_valid=0.
//  - State: FETCH (drop_cnt==0) and DRAIN (drop_cnt>0). Enter DRAIN on a redirect with
//    stale fetches in flight. Return to FETCH when drop_cnt reaches 0.
//  - Issue: imem_req_valid = !reset && !redirect_valid && (occupancy + outstanding - drop_cnt) < DEPTH.
//    Credit uses registered values only; a same-cycle dequeue frees no credit.
//    Issue is allowed in DRAIN.
//  - On an accepted request (valid & ready): fetch_pc += 4; outstanding += 1.
//  - Response: outstanding -= 1. If drop_cnt>0, discard the response and decrement drop_cnt.
//    Otherwise write {resp_pc, data} at the tail and advance resp_pc by 4.
//    The credit rule prevents overflow. A response while outstanding==0 is a protocol error
//    (assertion); the response is ignored.
//  - Dequeue: on deq_valid & deq_ready, the head pointer advances.
//    Enqueue and dequeue in the same cycle leave occupancy unchanged.
//    Pointers wrap modulo DEPTH.
//  - Latency: request accepted in cycle N, response in N+k (k>=1), deq_valid high in N+k+1.
//    There is no response-to-output bypass.
//  - Redirect (highest priority), applied next edge:
//    - occupancy=0 and both pointers reset.
//    - fetch_pc=resp_pc=redirect_pc.
//    - drop_cnt = outstanding - imem_resp_valid. A response arriving in the redirect cycle is discarded.
//    - A dequeue handshake in the same cycle still counts as consumed.
//    - No request is issued in the redirect cycle.
//    - A redirect during DRAIN reloads drop_cnt with the same formula.
//  - Reset mid-operation clears all state. Responses to pre-reset requests arriving after
//    reset are not tracked (memory is reset in the same cycle).
//  - PC arithmetic wraps modulo 2^PC_W. Redirect PC is taken as-is; no alignment check.
// CONFIGURATION
//  IF_PREFETCH_PERF_EN defined:
//    - Adds output perf_stall_cycles[31:0]: counts cycles with deq_valid & !deq_ready.
//    - Adds output perf_dropped[31:0]: counts discarded responses.
//    - Both counters saturate at 2^32-1 and are cleared by reset.
//  Not defined: these ports and counters do not exist. Behaviour is otherwise identical.
// TESTING
//  1. Reset, then imem_req_ready=1, 1-cycle response latency, deq_ready=1
//     -> requests to 0,4,8,...; deq_pc 0,4,8 on consecutive cycles after the first 2-cycle latency.
//  2. deq_ready=0 with DEPTH=4
//     -> exactly 4 requests issued, occupancy=4, imem_req_valid=0.
//     Raise deq_ready for 1 cycle -> one new request issued on the following cycle.
//  3. 3 requests in flight, redirect_pc=0x100 with no response that cycle
//     -> occupancy=0, next 3 responses discarded, first deq_pc=0x100.
//  4. Redirect in the same cycle as a response and a dequeue handshake
//     -> the dequeued entry is consumed once, the response is discarded, drop_cnt=outstanding-1.
//  5. Second redirect to 0x200 during DRAIN -> only post-0x200 fetches are delivered, starting at 0x200.
//  6. Assert reset mid-stream with occupancy=3
//     -> next cycle deq_valid=0, occupancy=0, and the first request goes to RESET_PC.
//     With IF_PREFETCH_PERF_EN: counters read 0.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch front end that sits ahead of the IF/ID pipeline register.
// It issues in-order fetch requests to instruction memory, buffers each
// returned instruction together with its PC in a small FIFO, and presents the
// head entry first-word-fall-through under a valid/ready handshake.
//
// A branch redirect from EX/MEM does the following:
//   - flushes the FIFO;
//   - restarts fetching at the new PC;
//   - arms a drop counter so that responses to stale in-flight requests are
//     discarded.
//
// Optional build macro:
//   IF_PREFETCH_PERF_EN - adds the saturating performance counters
//                         perf_stall_cycles and perf_dropped.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   imem_req_*        fetch request channel (valid/ready, address)
//   imem_resp_*       in-order response channel (valid, instruction)
//   redirect_*        taken-branch flush with new fetch PC
//   deq_*             FWFT output towards IF/ID (valid/ready, pc, instr)
//   occupancy         number of entries currently held
//   perf_* (optional) stall-cycle and dropped-response counters
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     PC_W     = 64,
   parameter int unsigned     INSTR_W  = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req_valid,
   output logic [PC_W-1:0]            imem_req_addr,
   input  logic                       imem_req_ready,
   input  logic                       imem_resp_valid,
   input  logic [INSTR_W-1:0]         imem_resp_data,
   input  logic                       redirect_valid,
   input  logic [PC_W-1:0]            redirect_pc,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [PC_W-1:0]            deq_pc,
   output logic [INSTR_W-1:0]         deq_instr,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef IF_PREFETCH_PERF_EN
   ,
   output logic [31:0]                perf_stall_cycles,
   output logic [31:0]                perf_dropped
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH+1);
   // Outstanding/drop counters need headroom beyond DEPTH: back-to-back
   // redirects while memory is slow keep issuing on top of pending drops.
   localparam int unsigned CNT_W = $clog2(DEPTH) + 4;
   localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(DEPTH);
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   typedef enum logic {ST_FETCH, ST_DRAIN} state_t;

   state_t              state_reg;
   logic [PC_W-1:0]     fetch_pc_reg;
   logic [PC_W-1:0]     resp_pc_reg;
   logic [OCC_W-1:0]    occ_reg;
   logic [CNT_W-1:0]    outstanding_reg;
   logic [CNT_W-1:0]    drop_cnt_reg;
   logic [PTR_W-1:0]    head_reg;
   logic [PTR_W-1:0]    tail_reg;

   logic [PC_W-1:0]     pc_mem    [DEPTH];
   logic [INSTR_W-1:0]  instr_mem [DEPTH];

   logic [CNT_W:0]      credit_used;
   logic [CNT_W-1:0]    redirect_drop;
   logic                req_fire;
   logic                resp_ok;
   logic                resp_drop;
   logic                enq;
   logic                deq_fire;

   // Credit counts live fetches only: stale requests still in flight hold no
   // FIFO slot. Only registered state is used, so a dequeue in this cycle
   // frees no credit until the next cycle.
   assign credit_used    = {1'b0, outstanding_reg} + (CNT_W+1)'(occ_reg)
                         - {1'b0, drop_cnt_reg};
   assign imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_C);
   assign imem_req_addr  = fetch_pc_reg;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol violation and is ignored.
   assign resp_ok        = imem_resp_valid && (outstanding_reg != '0);
   assign resp_drop      = resp_ok && (state_reg == ST_DRAIN);
   assign enq            = resp_ok && (state_reg == ST_FETCH) && !redirect_valid;

   assign deq_valid      = (occ_reg != '0);
   assign deq_fire       = deq_valid && deq_ready;
   assign deq_pc         = pc_mem[head_reg];
   assign deq_instr      = instr_mem[head_reg];
   assign occupancy      = occ_reg;

   // Every stale request still in flight must be dropped, except one whose
   // response is consumed (and discarded) in the redirect cycle itself.
   assign redirect_drop  = outstanding_reg - CNT_W'(resp_ok);

   // Payload storage: written only, never reset (contents are don't-care
   // while the entry is empty).
   always_ff @(posedge clk) begin
      if (!reset && enq) begin
         pc_mem[tail_reg]    <= resp_pc_reg;
         instr_mem[tail_reg] <= imem_resp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_FETCH;
         fetch_pc_reg    <= RESET_PC;
         resp_pc_reg     <= RESET_PC;
         occ_reg         <= '0;
         outstanding_reg <= '0;
         drop_cnt_reg    <= '0;
         head_reg        <= '0;
         tail_reg        <= '0;
      end else if (redirect_valid) begin
         // No request is issued in a redirect cycle, so outstanding only
         // loses the response (if any) that arrives now.
         fetch_pc_reg    <= redirect_pc;
         resp_pc_reg     <= redirect_pc;
         occ_reg         <= '0;
         head_reg        <= '0;
         tail_reg        <= '0;
         outstanding_reg <= redirect_drop;
         drop_cnt_reg    <= redirect_drop;
         state_reg       <= (redirect_drop != '0) ? ST_DRAIN : ST_FETCH;
      end else begin
         if (req_fire)
            fetch_pc_reg <= fetch_pc_reg + PC_STEP;

         case ({req_fire, resp_ok})
            2'b10:   outstanding_reg <= outstanding_reg + CNT_W'(1);
            2'b01:   outstanding_reg <= outstanding_reg - CNT_W'(1);
            default: outstanding_reg <= outstanding_reg;
         endcase

         if (resp_drop) begin
            drop_cnt_reg <= drop_cnt_reg - CNT_W'(1);
            if (drop_cnt_reg == CNT_W'(1))
               state_reg <= ST_FETCH;
         end

         if (enq) begin
            tail_reg    <= tail_reg + PTR_W'(1);
            resp_pc_reg <= resp_pc_reg + PC_STEP;
         end

         if (deq_fire)
            head_reg <= head_reg + PTR_W'(1);

         case ({enq, deq_fire})
            2'b10:   occ_reg <= occ_reg + OCC_W'(1);
            2'b01:   occ_reg <= occ_reg - OCC_W'(1);
            default: occ_reg <= occ_reg;
         endcase
      end
   end

`ifdef IF_PREFETCH_PERF_EN
   logic perf_drop_evt;

   // Includes the response discarded in a redirect cycle.
   assign perf_drop_evt = resp_ok && (redirect_valid || (state_reg == ST_DRAIN));

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_cycles <= '0;
         perf_dropped      <= '0;
      end else begin
         if (deq_valid && !deq_ready && (perf_stall_cycles != '1))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (perf_drop_evt && (perf_dropped != '1))
            perf_dropped <= perf_dropped + 32'd1;
      end
   end
`endif

   resp_without_request: assert property (@(posedge clk) disable iff (reset)
      !(imem_resp_valid && (outstanding_reg == '0)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_queue
//
// Directed bench for if_prefetch_queue (DEPTH=4, PC_W=64, INSTR_W=32,
// RESET_PC=0).
//
// The instruction memory is modelled by a queue of accepted addresses. It
// answers in order with a one-cycle latency while resp_en is set. The
// returned instruction is a fixed function of the address, so every output
// can be predicted independently of the design.
// -----------------------------------------------------------------------------
module tb_if_prefetch_queue;

   localparam int DEPTH   = 4;
   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       imem_req_valid;
   logic [PC_W-1:0]            imem_req_addr;
   logic                       imem_req_ready;
   logic                       imem_resp_valid;
   logic [INSTR_W-1:0]         imem_resp_data;
   logic                       redirect_valid;
   logic [PC_W-1:0]            redirect_pc;
   logic                       deq_valid;
   logic                       deq_ready;
   logic [PC_W-1:0]            deq_pc;
   logic [INSTR_W-1:0]         deq_instr;
   logic [$clog2(DEPTH+1)-1:0] occupancy;
`ifdef IF_PREFETCH_PERF_EN
   logic [31:0]                perf_stall_cycles;
   logic [31:0]                perf_dropped;
`endif

   int          n_chk    = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   int          req_cnt  = 0;
   int          deq0_cnt = 0;
   bit          resp_en  = 1'b0;
   logic [63:0] pend_q[$];

   always #5 clk = ~clk;

   if_prefetch_queue #(
      .DEPTH    (DEPTH),
      .PC_W     (PC_W),
      .INSTR_W  (INSTR_W),
      .RESET_PC (64'h0)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .deq_valid       (deq_valid),
      .deq_ready       (deq_ready),
      .deq_pc          (deq_pc),
      .deq_instr       (deq_instr),
      .occupancy       (occupancy)
`ifdef IF_PREFETCH_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_dropped      (perf_dropped)
`endif
   );

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[31:0] ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample handshakes, clock, then update the memory model.
   task automatic step();
      logic        rf;
      logic        sf;
      logic        rst_s;
      logic [63:0] ra;
      #1;
      rf    = imem_req_valid && imem_req_ready;
      ra    = imem_req_addr;
      sf    = imem_resp_valid;
      rst_s = reset;
      if (rf)
         $display("req  addr=%0h", ra);
      if (deq_valid && deq_ready) begin
         $display("deq  pc=%0h instr=%0h", deq_pc, deq_instr);
         if (deq_pc == 64'h0)
            deq0_cnt++;
      end
      @(posedge clk);
      #1;
      if (rst_s) begin
         pend_q.delete();
      end else begin
         if (sf)
            void'(pend_q.pop_front());
         if (rf) begin
            pend_q.push_back(ra);
            req_cnt++;
         end
      end
      if (resp_en && !reset && (pend_q.size() > 0)) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = instr_of(pend_q[0]);
      end else begin
         imem_resp_valid = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      resp_en        = 1'b0;
      imem_req_ready = 1'b0;
      deq_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      step();
      step();
      reset    = 1'b0;
      req_cnt  = 0;
      deq0_cnt = 0;
   endtask

   initial begin
      int waited;
      reset           = 1'b1;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      deq_ready       = 1'b0;

      // ---- reset state ------------------------------------------------------
      step();
      step();
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_deq_valid", deq_valid, 1'b0);
      chk("rst_occupancy", occupancy, 0);
`ifdef IF_PREFETCH_PERF_EN
      chk("rst_perf_stall", perf_stall_cycles, 0);
      chk("rst_perf_drop", perf_dropped, 0);
`endif

      // ---- 1: streaming with 1-cycle memory ---------------------------------
      reset = 1'b0; imem_req_ready = 1'b1; deq_ready = 1'b1; resp_en = 1'b1;
      #1;
      chk("t1_req_valid", imem_req_valid, 1'b1);
      chk("t1_addr0", imem_req_addr, 64'h0);
      chk("t1_deq_valid0", deq_valid, 1'b0);
      step();
      chk("t1_addr1", imem_req_addr, 64'h4);
      chk("t1_deq_valid1", deq_valid, 1'b0);
      step();
      chk("t1_deq_valid2", deq_valid, 1'b1);
      chk("t1_deq_pc0", deq_pc, 64'h0);
      chk("t1_deq_instr0", deq_instr, instr_of(64'h0));
      step();
      chk("t1_deq_pc4", deq_pc, 64'h4);
      step();
      chk("t1_deq_pc8", deq_pc, 64'h8);
      chk("t1_deq_instr8", deq_instr, instr_of(64'h8));
      chk("t1_occupancy", occupancy, 1);

      // ---- 2: back-pressure fills the queue ---------------------------------
      do_reset();
      imem_req_ready = 1'b1; deq_ready = 1'b0; resp_en = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("t2_req_cnt", req_cnt, 4);
      chk("t2_occupancy_full", occupancy, 4);
      chk("t2_req_valid_full", imem_req_valid, 1'b0);
      chk("t2_head_pc", deq_pc, 64'h0);
      deq_ready = 1'b1;
      #1;
      chk("t2_no_same_cycle_credit", imem_req_valid, 1'b0);
      step();
      deq_ready = 1'b0;
      #1;
      chk("t2_req_after_deq", imem_req_valid, 1'b1);
      chk("t2_req_addr16", imem_req_addr, 64'h10);
      step();
      chk("t2_req_cnt5", req_cnt, 5);
      chk("t2_req_valid_again0", imem_req_valid, 1'b0);
      chk("t2_head_pc4", deq_pc, 64'h4);
      chk("t2_occupancy3", occupancy, 3);
      step();
      chk("t2_occupancy4", occupancy, 4);

      // ---- 3: redirect with 3 in flight, no response that cycle -------------
      do_reset();
      imem_req_ready = 1'b1; deq_ready = 1'b1; resp_en = 1'b0;
      step(); step(); step();
      redirect_valid = 1'b1; redirect_pc = 64'h100; resp_en = 1'b1;
      #1;
      chk("t3_no_req_on_redirect", imem_req_valid, 1'b0);
      step();
      redirect_valid = 1'b0;
      #1;
      chk("t3_occ_after_redirect", occupancy, 0);
      chk("t3_req_addr100", imem_req_addr, 64'h100);
      step(); step(); step();
      chk("t3_stale_dropped", occupancy, 0);
      chk("t3_no_stale_deq", deq_valid, 1'b0);
      step();
      chk("t3_deq_valid", deq_valid, 1'b1);
      chk("t3_deq_pc100", deq_pc, 64'h100);
      chk("t3_deq_instr100", deq_instr, instr_of(64'h100));
      step();
      chk("t3_deq_pc104", deq_pc, 64'h104);

      // ---- 4: redirect together with a response and a dequeue ---------------
      do_reset();
      imem_req_ready = 1'b1; deq_ready = 1'b1; resp_en = 1'b0;
      step(); step();
      resp_en = 1'b1;
      step(); step();
      chk("t4_pre_deq_valid", deq_valid, 1'b1);
      chk("t4_pre_deq_pc0", deq_pc, 64'h0);
      chk("t4_resp_in_redirect", imem_resp_valid, 1'b1);
      redirect_valid = 1'b1; redirect_pc = 64'h300;
      step();
      redirect_valid = 1'b0;
      #1;
      chk("t4_occ_after_redirect", occupancy, 0);
      chk("t4_req_addr300", imem_req_addr, 64'h300);
      step(); step();
      chk("t4_stale_dropped", occupancy, 0);
      step();
      chk("t4_deq_valid", deq_valid, 1'b1);
      chk("t4_deq_pc300", deq_pc, 64'h300);
      chk("t4_entry0_consumed_once", deq0_cnt, 1);

      // ---- 5: second redirect while draining --------------------------------
      do_reset();
      imem_req_ready = 1'b1; deq_ready = 1'b1; resp_en = 1'b0;
      step(); step(); step();
      redirect_valid = 1'b1; redirect_pc = 64'h100;
      step();
      redirect_valid = 1'b0;
      #1;
      chk("t5_req_addr100", imem_req_addr, 64'h100);
      step();
      redirect_valid = 1'b1; redirect_pc = 64'h200; resp_en = 1'b1;
      step();
      redirect_valid = 1'b0;
      waited = 0;
      while (!deq_valid && (waited < 20)) begin
         step();
         waited++;
      end
      chk("t5_deq_timeout", deq_valid, 1'b1);
      chk("t5_latency", waited, 5);
      chk("t5_deq_pc200", deq_pc, 64'h200);
      chk("t5_deq_instr200", deq_instr, instr_of(64'h200));
      step();
      chk("t5_deq_pc204", deq_pc, 64'h204);
`ifdef IF_PREFETCH_PERF_EN
      chk("t5_perf_dropped", perf_dropped, 4);
`endif

      // ---- 6: reset mid-stream ----------------------------------------------
      do_reset();
      imem_req_ready = 1'b1; deq_ready = 1'b0; resp_en = 1'b1;
      step(); step(); step(); step();
      chk("t6_occupancy3", occupancy, 3);
      reset = 1'b1;
      step();
      chk("t6_deq_valid", deq_valid, 1'b0);
      chk("t6_occupancy0", occupancy, 0);
      chk("t6_req_valid_in_reset", imem_req_valid, 1'b0);
`ifdef IF_PREFETCH_PERF_EN
      chk("t6_perf_stall", perf_stall_cycles, 0);
      chk("t6_perf_drop", perf_dropped, 0);
`endif
      reset = 1'b0;
      #1;
      chk("t6_req_valid", imem_req_valid, 1'b1);
      chk("t6_req_reset_pc", imem_req_addr, 64'h0);
      step();
      chk("t6_no_stale_deq", deq_valid, 1'b0);
      step();
      chk("t6_deq_pc0", deq_pc, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
